// File: rtl/mem_responder.sv
// Load/store responder with a word-organised synchronous RAM.
// Sub-word stores use read-modify-write; loads are sign- or zero-extended.
module mem_responder #(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter              INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [1:0]  dbg_state
);

   localparam int AW = $clog2(DEPTH);

   // Handshakes: a request transfers on a rising edge with req_valid && req_ready;
   // a response transfers on a rising edge with resp_valid && resp_ready.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            we_q, we_d;
   logic [2:0]      f3_q, f3_d;
   logic [1:0]      lane_q, lane_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            err_q, err_d;
   logic [31:0]     word_q;
   logic [31:0]     mem [DEPTH];

   logic [31:0]     off;
   logic            req_err;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [31:0]     load_data;
   logic [31:0]     merged;

   assign off = req_addr - BASE_ADDR;

   always_comb begin
      req_err = 1'b0;
      case (req_funct3)
         3'b011, 3'b110, 3'b111: req_err = 1'b1;
         3'b100, 3'b101:         if (req_we) req_err = 1'b1;
         default: ;
      endcase
      if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_err = 1'b1;
      if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00) req_err = 1'b1;
      if (req_addr < BASE_ADDR || {2'b00, off[31:2]} >= 32'(DEPTH)) req_err = 1'b1;
   end

   assign byte_sel = word_q[8*lane_q +: 8];
   assign half_sel = lane_q[1] ? word_q[31:16] : word_q[15:0];

   always_comb begin
      load_data = word_q;
      case (f3_q)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_data = {24'h0, byte_sel};
         3'b101:  load_data = {16'h0, half_sel};
         default: load_data = word_q;
      endcase
   end

   // Untouched lanes come from the word captured during READ.
   always_comb begin
      merged = word_q;
      case (f3_q[1:0])
         2'b00: merged[8*lane_q +: 8] = wdata_q[7:0];
         2'b01: begin
            if (lane_q[1]) merged[31:16] = wdata_q[15:0];
            else           merged[15:0]  = wdata_q[15:0];
         end
         default: merged = wdata_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      lane_d  = lane_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               lane_d  = off[1:0];
               idx_d   = off[AW+1:2];
               wdata_d = req_wdata;
               err_d   = req_err;
               state_d = req_err ? S_RESP : S_READ;
            end
         end
         S_READ:  state_d = we_q ? S_WRITE : S_RESP;
         S_WRITE: state_d = S_RESP;
         S_RESP:  if (resp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         lane_q  <= 2'b00;
         idx_q   <= '0;
         wdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         lane_q  <= lane_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   // A reset that lands before the WRITE edge leaves state_q in IDLE, so no write.
   always_ff @(posedge clk) begin
      if (state_q == S_READ)  word_q       <= mem[idx_q];
      if (state_q == S_WRITE) mem[idx_q]   <= merged;
   end

   assign req_ready  = (state_q == S_IDLE) && reset;
   assign resp_valid = (state_q == S_RESP);
   assign resp_err   = (state_q == S_RESP) && err_q;
   assign resp_rdata = (state_q == S_RESP && !we_q && !err_q) ? load_data : 32'h0;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized bench for mem_responder against a byte-addressed model.
module tb_mem_responder;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [2:0]  req_funct3 = 3'b000;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [1:0]  dbg_state;

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;

   logic [7:0]  mb [0:4*DEPTH-1];
   logic [31:0] exp_q[$];

   mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .INIT_FILE("")) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic bit model_err(input logic we, input logic [31:0] a, input logic [2:0] f3);
      int size;
      if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
      if (we && f3[2]) return 1'b1;
      size = 1 << f3[1:0];
      if (a % size != 0) return 1'b1;
      if (a >= 4 * DEPTH) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
      int size;
      logic [31:0] v;
      size = 1 << f3[1:0];
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(mb[a + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 1);
      return v;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
      int size;
      size = 1 << f3[1:0];
      for (int i = 0; i < size; i++) mb[a + i] = wd[8*i +: 8];
   endtask

   task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3, output logic [31:0] rd);
      bit e;
      int lat;
      int exp_lat;
      int w;
      e = model_err(we, addr, f3);
      exp_lat = e ? 1 : (we ? 3 : 2);
      exp_q.push_back((e || we) ? 32'h0 : model_load(addr, f3));
      w = 0;
      while (!req_ready && w < 10) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_wdata  = wd;
      req_funct3 = f3;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom_range(0, 1));
      req_addr   = $urandom();
      req_wdata  = $urandom();
      req_funct3 = 3'($urandom_range(0, 7));
      lat = 0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = n;
            break;
         end
      end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      rd = resp_rdata;
      chk({tag, "_rdata"}, resp_rdata, exp_q.pop_front());
      chk({tag, "_err"}, 32'(resp_err), 32'(e));
      if (!e && we) model_store(addr, wd, f3);
      if (lat != 0) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] held;
      logic [31:0] a;
      logic [2:0]  f3;
      logic        we;
      bit          seen;

      // reset behaviour
      #3;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);

      // word, byte and halfword stores with readback
      xact("sw10", 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, rd);
      chk("sw10_const", rd, 32'h0);
      xact("lw10a", 1'b0, 32'h10, 32'h0, 3'b010, rd);
      chk("lw10a_const", rd, 32'hDEAD_BEEF);
      xact("sb13", 1'b1, 32'h13, 32'h0000_00AA, 3'b000, rd);
      xact("lw10b", 1'b0, 32'h10, 32'h0, 3'b010, rd);
      chk("lw10b_const", rd, 32'hAAAD_BEEF);
      xact("sh10", 1'b1, 32'h10, 32'h0000_1234, 3'b001, rd);
      xact("lw10c", 1'b0, 32'h10, 32'h0, 3'b010, rd);
      chk("lw10c_const", rd, 32'hAAAD_1234);

      // extension variants
      xact("sw20", 1'b1, 32'h20, 32'h0000_8080, 3'b010, rd);
      xact("lb20", 1'b0, 32'h20, 32'h0, 3'b000, rd);
      chk("lb20_const", rd, 32'hFFFF_FF80);
      xact("lbu20", 1'b0, 32'h20, 32'h0, 3'b100, rd);
      chk("lbu20_const", rd, 32'h0000_0080);
      xact("lh20", 1'b0, 32'h20, 32'h0, 3'b001, rd);
      chk("lh20_const", rd, 32'hFFFF_8080);
      xact("lhu20", 1'b0, 32'h20, 32'h0, 3'b101, rd);
      chk("lhu20_const", rd, 32'h0000_8080);

      // rejected accesses
      xact("lw22", 1'b0, 32'h22, 32'h0, 3'b010, rd);
      xact("sw21", 1'b1, 32'h21, 32'hFFFF_FFFF, 3'b010, rd);
      xact("lw20_after", 1'b0, 32'h20, 32'h0, 3'b010, rd);
      chk("lw20_after_const", rd, 32'h0000_8080);
      xact("f3_011", 1'b0, 32'h20, 32'h0, 3'b011, rd);
      xact("oob", 1'b0, 32'(4 * DEPTH), 32'h0, 3'b010, rd);
      xact("sbu_store", 1'b1, 32'h24, 32'h1, 3'b100, rd);

      // response back-pressure
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_addr   = 32'h10;
      req_funct3 = 3'b010;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("hold_valid_first", 32'(resp_valid), 32'd1);
      held = resp_rdata;
      chk("hold_rdata_first", held, 32'hAAAD_1234);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_valid", 32'(resp_valid), 32'd1);
         chk("hold_rdata", resp_rdata, held);
         chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("release_valid", 32'(resp_valid), 32'd0);
      chk("release_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);

      // reset in the middle of a read-modify-write
      xact("sw30", 1'b1, 32'h30, 32'h1122_3344, 3'b010, rd);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_addr   = 32'h30;
      req_wdata  = 32'h55;
      req_funct3 = 3'b000;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_release_ready", 32'(req_ready), 32'd1);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      chk("midrst_no_response", 32'(seen), 32'd0);
      xact("lw30", 1'b0, 32'h30, 32'h0, 3'b010, rd);
      chk("lw30_const", rd, 32'h1122_3344);

      // randomized traffic over a preloaded window
      for (int i = 0; i < 16; i++)
         xact("init", 1'b1, 32'h100 + 32'(4 * i), $urandom(), 3'b010, rd);
      for (int i = 0; i < 60; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 7))
            0:       a = 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
            1:       a = 32'hFFFF_FFFC;
            default: a = 32'h100 + 32'($urandom_range(0, 63));
         endcase
         xact("rand", we, a, $urandom(), f3, rd);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
